stopwatch_lap_ctrl: RTL and testbench

Parametrised stopwatch/timer core clocked at 100 Hz (one clock = 10 ms). It holds an MM:SS.cc BCD time, counts up or (optionally) down, and stores lap captures in an on-chip buffer. It drives a registered display selection of live time or any stored lap. It sits between the debounced button pulses and the 7-segment scan driver.

---
 rtl/stopwatch_pkg.sv | 46 ++++
 rtl/bcd_time_counter.sv | 96 +++++++++
 rtl/stopwatch_lap_ctrl.sv | 136 +++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types, digit limits and preset sanitising for the stopwatch
package stopwatch_pkg;

  // MM:SS.cc as six BCD digits, packed in display order
  typedef struct packed {
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
    logic [3:0] cs_h;
    logic [3:0] cs_l;
  } bcd_time_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } sw_state_e;

  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] SEC_H_MAX = 4'd5;

  // Clamp each digit to its legal range, then clamp minutes to max_min.
  function automatic bcd_time_t bcd_sanitise(input bcd_time_t raw, input int unsigned max_min);
    bcd_time_t  t;
    logic [3:0] mx_h;
    logic [3:0] mx_l;
    t = raw;
    if (t.min_h > DIGIT_MAX) t.min_h = DIGIT_MAX;
    if (t.min_l > DIGIT_MAX) t.min_l = DIGIT_MAX;
    if (t.sec_h > SEC_H_MAX) t.sec_h = SEC_H_MAX;
    if (t.sec_l > DIGIT_MAX) t.sec_l = DIGIT_MAX;
    if (t.cs_h  > DIGIT_MAX) t.cs_h  = DIGIT_MAX;
    if (t.cs_l  > DIGIT_MAX) t.cs_l  = DIGIT_MAX;
    mx_h = 4'(max_min / 10);
    mx_l = 4'(max_min % 10);
    // With valid BCD digits the byte compare orders minutes numerically
    if ({t.min_h, t.min_l} > {mx_h, mx_l}) begin
      t.min_h = mx_h;
      t.min_l = mx_l;
    end
    return t;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - cascaded BCD time chain; decrement path only with STOPWATCH_COUNTDOWN_EN
module bcd_time_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input  logic      clk_100hz,
  input  logic      rst_n,
  input  logic      clr,
  input  logic      load,
  input  bcd_time_t load_val,
  input  logic      en,
  input  logic      down,
  output bcd_time_t value,
  output logic      at_max,
  output logic      at_zero
);

  localparam logic [3:0] MAX_MIN_H = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MIN_L = 4'(MAX_MIN % 10);

  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] lim);
    return (d == lim) ? 4'd0 : d + 4'd1;
  endfunction

  bcd_time_t nxt_up;

  assign at_max  = (value == {MAX_MIN_H, MAX_MIN_L, SEC_H_MAX, DIGIT_MAX, DIGIT_MAX, DIGIT_MAX});
  assign at_zero = (value == '0);

  // Up chain: each digit advances only when every lower digit wraps
  always_comb begin
    nxt_up      = value;
    nxt_up.cs_l = wrap_inc(value.cs_l, DIGIT_MAX);
    if (value.cs_l == DIGIT_MAX) begin
      nxt_up.cs_h = wrap_inc(value.cs_h, DIGIT_MAX);
      if (value.cs_h == DIGIT_MAX) begin
        nxt_up.sec_l = wrap_inc(value.sec_l, DIGIT_MAX);
        if (value.sec_l == DIGIT_MAX) begin
          nxt_up.sec_h = wrap_inc(value.sec_h, SEC_H_MAX);
          if (value.sec_h == SEC_H_MAX) begin
            nxt_up.min_l = wrap_inc(value.min_l, DIGIT_MAX);
            if (value.min_l == DIGIT_MAX) nxt_up.min_h = value.min_h + 4'd1;
          end
        end
      end
    end
  end

`ifdef STOPWATCH_COUNTDOWN_EN
  function automatic logic [3:0] wrap_dec(input logic [3:0] d, input logic [3:0] lim);
    return (d == 4'd0) ? lim : d - 4'd1;
  endfunction

  bcd_time_t nxt_dn;

  // Down chain: each digit borrows only when every lower digit is zero
  always_comb begin
    nxt_dn      = value;
    nxt_dn.cs_l = wrap_dec(value.cs_l, DIGIT_MAX);
    if (value.cs_l == 4'd0) begin
      nxt_dn.cs_h = wrap_dec(value.cs_h, DIGIT_MAX);
      if (value.cs_h == 4'd0) begin
        nxt_dn.sec_l = wrap_dec(value.sec_l, DIGIT_MAX);
        if (value.sec_l == 4'd0) begin
          nxt_dn.sec_h = wrap_dec(value.sec_h, SEC_H_MAX);
          if (value.sec_h == 4'd0) begin
            nxt_dn.min_l = wrap_dec(value.min_l, DIGIT_MAX);
            if (value.min_l == 4'd0) nxt_dn.min_h = value.min_h - 4'd1;
          end
        end
      end
    end
  end

  // Time register: clear beats load beats count
  always_ff @(posedge clk_100hz or negedge rst_n) begin
    if (!rst_n)    value <= '0;
    else if (clr)  value <= '0;
    else if (load) value <= load_val;
    else if (en)   value <= down ? nxt_dn : nxt_up;
  end
`else
  logic unused_down;
  assign unused_down = down;

  // Time register: clear beats load beats count
  always_ff @(posedge clk_100hz or negedge rst_n) begin
    if (!rst_n)    value <= '0;
    else if (clr)  value <= '0;
    else if (load) value <= load_val;
    else if (en)   value <= nxt_up;
  end
`endif

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// rtl/stopwatch_lap_ctrl.sv - stopwatch FSM, lap buffer and display mux; countdown via STOPWATCH_COUNTDOWN_EN
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN   = 59,
  parameter int LAP_DEPTH = 4,
  parameter int LW        = $clog2(LAP_DEPTH)
) (
  input  logic          clk_100hz,
  input  logic          rst_n,
  input  logic          start_stop,
  input  logic          lap,
  input  logic          clear,
  input  logic          mode_down,
  input  logic [23:0]   preset,
  input  logic          view_lap,
  input  logic [LW-1:0] lap_sel,
  output logic [23:0]   disp,
  output logic [LW:0]   lap_cnt,
  output logic          lap_full,
  output logic          lap_ovf,
  output logic          running,
  output logic          time_out
);

  localparam logic [LW:0] CNT_ONE = (LW + 1)'(1);

  sw_state_e state;
  logic      mode_dn;
  logic      down_sel;
  bcd_time_t preset_clean;
  bcd_time_t time_q;
  logic      at_max;
  logic      at_zero;
  logic      hit_end;
  logic      cnt_en;
  logic      cnt_load;
  bcd_time_t lap_mem [LAP_DEPTH];

`ifdef STOPWATCH_COUNTDOWN_EN
  assign down_sel     = mode_down;
  assign preset_clean = bcd_sanitise(preset, MAX_MIN);
`else
  logic unused_cfg;
  assign down_sel     = 1'b0;
  assign preset_clean = '0;
  assign unused_cfg   = ^{mode_down, preset};
`endif

  // Down mode ends on the decrement that lands on zero (or immediately on a zero preset)
  assign hit_end  = mode_dn ? (at_zero || (time_q == 24'h000001)) : at_max;
  assign cnt_en   = (state == S_RUN) && !start_stop && !(mode_dn ? at_zero : at_max);
  assign cnt_load = (state == S_IDLE) && start_stop && down_sel;
  // Count never exceeds LAP_DEPTH, a power of two, so its top bit marks full
  assign lap_full = lap_cnt[LW];

  bcd_time_counter #(.MAX_MIN(MAX_MIN)) u_counter (
    .clk_100hz (clk_100hz),
    .rst_n     (rst_n),
    .clr       (clear),
    .load      (cnt_load),
    .load_val  (preset_clean),
    .en        (cnt_en),
    .down      (mode_dn),
    .value     (time_q),
    .at_max    (at_max),
    .at_zero   (at_zero)
  );

  // Run/hold/done state machine with registered running and time_out
  always_ff @(posedge clk_100hz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mode_dn  <= 1'b0;
      running  <= 1'b0;
      time_out <= 1'b0;
    end else begin
      time_out <= 1'b0;
      if (clear) begin
        state   <= S_IDLE;
        mode_dn <= 1'b0;
        running <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start_stop) begin
            state   <= S_RUN;
            mode_dn <= down_sel;
            running <= 1'b1;
          end
          S_RUN: if (start_stop) begin
            state   <= S_HOLD;
            running <= 1'b0;
          end else if (hit_end) begin
            state    <= S_DONE;
            running  <= 1'b0;
            time_out <= 1'b1;
          end
          S_HOLD: if (start_stop) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
          S_DONE: ;
          default: begin
            state   <= S_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end

  // Lap buffer: append the pre-edge time, or flag overflow when full
  always_ff @(posedge clk_100hz or negedge rst_n) begin
    if (!rst_n || clear) begin
      lap_cnt <= '0;
      lap_ovf <= 1'b0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem[i] <= '0;
    end else if (lap && (state != S_IDLE)) begin
      if (lap_full) begin
        lap_ovf <= 1'b1;
      end else begin
        lap_mem[lap_cnt[LW-1:0]] <= time_q;
        lap_cnt                  <= lap_cnt + CNT_ONE;
      end
    end
  end

  // Registered display select: live time or a stored lap (zero if not yet stored)
  always_ff @(posedge clk_100hz or negedge rst_n) begin
    if (!rst_n)        disp <= '0;
    else if (!view_lap) disp <= time_q;
    else if ({1'b0, lap_sel} < lap_cnt) disp <= lap_mem[lap_sel];
    else               disp <= '0;
  end

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb/tb_stopwatch_lap_ctrl.sv - scoreboard bench for stopwatch_lap_ctrl; countdown checks with STOPWATCH_COUNTDOWN_EN
module tb_stopwatch_lap_ctrl;

  localparam int MAX_MIN   = 1;
  localparam int LAP_DEPTH = 4;
  localparam int LW        = 2;
  localparam int T_MAX     = MAX_MIN * 6000 + 5999;
`ifdef STOPWATCH_COUNTDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2, M_DONE = 3;

  logic          clk_100hz = 1'b0;
  logic          rst_n;
  logic          start_stop, lap, clear, mode_down, view_lap;
  logic [23:0]   preset;
  logic [LW-1:0] lap_sel;
  logic [23:0]   disp;
  logic [LW:0]   lap_cnt;
  logic          lap_full, lap_ovf, running, time_out;

  stopwatch_lap_ctrl #(.MAX_MIN(MAX_MIN), .LAP_DEPTH(LAP_DEPTH)) dut (
    .clk_100hz (clk_100hz),
    .rst_n     (rst_n),
    .start_stop(start_stop),
    .lap       (lap),
    .clear     (clear),
    .mode_down (mode_down),
    .preset    (preset),
    .view_lap  (view_lap),
    .lap_sel   (lap_sel),
    .disp      (disp),
    .lap_cnt   (lap_cnt),
    .lap_full  (lap_full),
    .lap_ovf   (lap_ovf),
    .running   (running),
    .time_out  (time_out)
  );

  always #5 clk_100hz = ~clk_100hz;

  int n_cmp = 0;
  int n_err = 0;
  logic [30:0] exp_q[$];

  // Reference model: time as plain centiseconds, laps as a queue
  int          m_st, m_t;
  int          m_laps[$];
  bit          m_ovf, m_tout, m_down;
  logic [23:0] m_disp;

  bit          g_vl, g_md;
  int          g_sel;
  logic [23:0] g_pre;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: actual %h required %h", name, $time, act, expv);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int t);
    int m, s, c;
    m = t / 6000;
    s = (t / 100) % 60;
    c = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic int sanitise(input logic [23:0] p);
    int d[6];
    int mins;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(p[23 - 4 * i -: 4]);
      if (d[i] > 9) d[i] = 9;
    end
    if (d[2] > 5) d[2] = 5;
    mins = d[0] * 10 + d[1];
    if (mins > MAX_MIN) mins = MAX_MIN;
    return mins * 6000 + (d[2] * 10 + d[3]) * 100 + d[4] * 10 + d[5];
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_t = 0; m_laps.delete();
    m_ovf = 0; m_tout = 0; m_down = 0; m_disp = '0;
  endtask

  task automatic model_step(input bit ss, input bit lp, input bit clr, input bit md,
                            input logic [23:0] pre, input bit vl, input int sel);
    if (vl) m_disp = (sel < m_laps.size()) ? to_bcd(m_laps[sel]) : 24'h0;
    else    m_disp = to_bcd(m_t);
    if (clr) begin
      m_st = M_IDLE; m_t = 0; m_laps.delete(); m_ovf = 0; m_tout = 0; m_down = 0;
    end else begin
      m_tout = 0;
      if (lp && m_st != M_IDLE) begin
        if (m_laps.size() < LAP_DEPTH) m_laps.push_back(m_t);
        else m_ovf = 1;
      end
      case (m_st)
        M_IDLE: if (ss) begin
          m_st = M_RUN;
          m_down = CD_EN && md;
          if (m_down) m_t = sanitise(pre);
        end
        M_RUN: begin
          if (ss) m_st = M_HOLD;
          else if (m_down) begin
            if (m_t > 0) m_t--;
            if (m_t == 0) begin m_st = M_DONE; m_tout = 1; end
          end else if (m_t == T_MAX) begin
            m_st = M_DONE; m_tout = 1;
          end else m_t++;
        end
        M_HOLD: if (ss) m_st = M_RUN;
        default: ;
      endcase
    end
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard
  task automatic drive(input bit ss, input bit lp, input bit clr);
    start_stop = ss; lap = lp; clear = clr;
    mode_down = g_md; preset = g_pre; view_lap = g_vl; lap_sel = LW'(g_sel);
    model_step(ss, lp, clr, g_md, g_pre, g_vl, g_sel);
    exp_q.push_back({m_disp, 3'(m_laps.size()), m_laps.size() == LAP_DEPTH, m_ovf,
                     m_st == M_RUN, m_tout});
    @(posedge clk_100hz);
    #2;
    start_stop = 0; lap = 0; clear = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  function automatic logic [30:0] outs();
    return {disp, lap_cnt, lap_full, lap_ovf, running, time_out};
  endfunction

  // Monitor: after every edge that stimulus was issued for, compare against the scoreboard
  initial begin : monitor
    logic [30:0] e;
    forever begin
      @(posedge clk_100hz);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("outputs{disp,cnt,full,ovf,run,tout}", 32'(outs()), 32'(e));
      end
    end
  end

  initial begin : stim
    rst_n = 0; start_stop = 0; lap = 0; clear = 0; mode_down = 0;
    preset = '0; view_lap = 0; lap_sel = '0;
    g_vl = 0; g_md = 0; g_sel = 0; g_pre = '0;
    model_reset();
    #12;
    chk("reset_outputs", 32'(outs()), 32'h0);
    @(negedge clk_100hz);
    rst_n = 1;

    // One minute run then stop
    drive(1, 0, 0);
    idle(6000);
    drive(1, 0, 0);
    chk("one_min_disp", 32'(disp), 32'h010000);
    chk("one_min_running", 32'(running), 32'h0);
    idle(10);
    chk("one_min_disp_held", 32'(disp), 32'h010000);

    // Saturation at MAX_MIN:59.99
    drive(0, 0, 1);
    drive(1, 0, 0);
    idle(12000);
    chk("sat_time_out", 32'(time_out), 32'h1);
    chk("sat_running", 32'(running), 32'h0);
    drive(1, 0, 0);
    chk("sat_time_out_once", 32'(time_out), 32'h0);
    chk("sat_disp", 32'(disp), 32'h015999);
    idle(2);
    chk("sat_ignores_start", 32'(running), 32'h0);

    // Five laps into a four-deep buffer
    drive(0, 0, 1);
    drive(1, 0, 0);
    for (int i = 1; i <= 51; i++) drive(0, (i > 1) && ((i - 1) % 10 == 0), 0);
    g_vl = 1; g_sel = 3;
    drive(0, 0, 0);
    chk("lap3_disp", 32'(disp), 32'h000040);
    chk("lap_cnt_full", 32'(lap_cnt), 32'd4);
    chk("lap_full", 32'(lap_full), 32'h1);
    chk("lap_ovf", 32'(lap_ovf), 32'h1);
    g_sel = 5;
    g_vl = 0;

    // Simultaneous stop and lap, then clear
    drive(0, 0, 1);
    drive(1, 0, 0);
    idle(123);
    drive(1, 1, 0);
    g_vl = 1; g_sel = 0;
    drive(0, 0, 0);
    chk("lap0_disp", 32'(disp), 32'h000123);
    chk("stop_lap_hold", 32'(running), 32'h0);
    chk("stop_lap_cnt", 32'(lap_cnt), 32'd1);
    drive(0, 1, 1);
    g_vl = 0;
    drive(0, 0, 0);
    chk("clear_cnt", 32'(lap_cnt), 32'h0);
    chk("clear_ovf", 32'(lap_ovf), 32'h0);
    chk("clear_disp", 32'(disp), 32'h0);

`ifdef STOPWATCH_COUNTDOWN_EN
    g_md = 1; g_pre = 24'h000005;
    drive(1, 0, 0);
    idle(5);
    chk("cd_time_out", 32'(time_out), 32'h1);
    chk("cd_running", 32'(running), 32'h0);
    idle(1);
    chk("cd_disp_zero", 32'(disp), 32'h0);
    chk("cd_time_out_once", 32'(time_out), 32'h0);
    drive(0, 0, 1);
    g_pre = 24'hFF7AB3;
    drive(1, 0, 0);
    drive(1, 0, 0);
    idle(1);
    chk("cd_clamped_preset", 32'(disp), 32'h015993);
    g_md = 0;
`endif

    // Randomised traffic, with one asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) g_vl = 1'($urandom_range(0, 1));
      g_sel = $urandom_range(0, LAP_DEPTH - 1);
      g_md  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) g_pre = 24'($urandom);
      else g_pre = {16'h0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 15))};
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 99) == 0));
      if (i == 1500) begin
        rst_n = 0;
        #1;
        chk("async_reset_outputs", 32'(outs()), 32'h0);
        @(negedge clk_100hz);
        rst_n = 1;
        model_reset();
      end
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
